// File: rtl/xgmii_decoder_64b66b.sv
// Clause 49 receive decoder: descrambled 66-bit blocks in, one XGMII data/ctrl word out per valid block.
// One-cycle registered latency; no backpressure (i_rx_valid gaps hold state and outputs, valid drops).
module xgmii_decoder_64b66b #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = 8,
  parameter int HDR_WIDTH     = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [DATA_WIDTH-1:0]    i_rx_data,
  input  logic [HDR_WIDTH-1:0]     i_rx_hdr,
  input  logic                     i_rx_valid,
  input  logic                     i_block_lock,
  output logic [DATA_WIDTH-1:0]    o_xgmii_data,
  output logic [CTRL_WIDTH-1:0]    o_xgmii_ctrl,
  output logic                     o_xgmii_valid,
  output logic                     o_decode_err,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

  localparam logic [HDR_WIDTH-1:0]  SYNC_DATA = 2'b01;
  localparam logic [HDR_WIDTH-1:0]  SYNC_CTRL = 2'b10;

  localparam logic [7:0] BT_C8    = 8'h1E;
  localparam logic [7:0] BT_C4_O4 = 8'h2D;
  localparam logic [7:0] BT_C4_S4 = 8'h33;
  localparam logic [7:0] BT_O4_O0 = 8'h55;
  localparam logic [7:0] BT_O0_S4 = 8'h66;
  localparam logic [7:0] BT_S0    = 8'h78;
  localparam logic [7:0] BT_O0_C4 = 8'h4B;
  localparam logic [7:0] BT_T0    = 8'h87;
  localparam logic [7:0] BT_T1    = 8'h99;
  localparam logic [7:0] BT_T2    = 8'hAA;
  localparam logic [7:0] BT_T3    = 8'hB4;
  localparam logic [7:0] BT_T4    = 8'hCC;
  localparam logic [7:0] BT_T5    = 8'hD2;
  localparam logic [7:0] BT_T6    = 8'hE1;
  localparam logic [7:0] BT_T7    = 8'hFF;

  localparam logic [DATA_WIDTH-1:0] LF_DATA  = 64'h0100009C_0100009C;
  localparam logic [CTRL_WIDTH-1:0] LF_CTRL  = 8'h11;
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = {8{8'hFE}};

  typedef enum logic [1:0] {RX_INIT, RX_C, RX_D, RX_E} state_t;
  typedef enum logic [2:0] {CLS_C, CLS_S, CLS_D, CLS_T, CLS_E} blk_cls_t;

  state_t                  state;
  state_t                  state_nxt;
  blk_cls_t                cls;
  logic [DATA_WIDTH-1:0]   dec_data;
  logic [CTRL_WIDTH-1:0]   dec_ctrl;
  logic [DATA_WIDTH-1:0]   tail_data;
  logic [2:0]              term_lane;
  logic                    is_term;
  logic                    codes_ok;

  function automatic logic [7:0] ctl_7to8(input logic [6:0] c);
    case (c)
      7'h00:   return 8'h07;
      7'h06:   return 8'h06;
      7'h1E:   return 8'hFE;
      7'h2D:   return 8'h1C;
      7'h33:   return 8'h3C;
      7'h4B:   return 8'h7C;
      7'h55:   return 8'hBC;
      7'h66:   return 8'hDC;
      7'h78:   return 8'hF7;
      default: return 8'hFE;
    endcase
  endfunction

  function automatic logic ctl_known(input logic [6:0] c);
    case (c)
      7'h00, 7'h06, 7'h1E, 7'h2D, 7'h33, 7'h4B, 7'h55, 7'h66, 7'h78: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic o_known(input logic [3:0] o);
    return (o == 4'h0) || (o == 4'hF);
  endfunction

  function automatic logic [7:0] o_to8(input logic [3:0] o);
    return (o == 4'h0) ? 8'h9C : 8'h5C;
  endfunction

  // Terminate data starts right after the type byte; pre-shifting keeps lane selects in range.
  assign tail_data = i_rx_data >> 8;

  always_comb begin
    cls       = CLS_E;
    dec_data  = '0;
    dec_ctrl  = '0;
    term_lane = 3'd0;
    is_term   = 1'b0;
    codes_ok  = 1'b1;
    if (i_rx_hdr == SYNC_DATA) begin
      cls      = CLS_D;
      dec_data = i_rx_data;
    end else if (i_rx_hdr == SYNC_CTRL) begin
      case (i_rx_data[7:0])
        BT_C8: begin
          for (int i = 0; i < 8; i++) begin
            dec_data[8*i +: 8] = ctl_7to8(i_rx_data[8+7*i +: 7]);
            codes_ok = codes_ok & ctl_known(i_rx_data[8+7*i +: 7]);
          end
          dec_ctrl = 8'hFF;
          cls      = codes_ok ? CLS_C : CLS_E;
        end
        BT_C4_O4: begin
          for (int i = 0; i < 4; i++) dec_data[8*i +: 8] = ctl_7to8(i_rx_data[8+7*i +: 7]);
          dec_data[39:32] = o_to8(i_rx_data[39:36]);
          dec_data[63:40] = i_rx_data[63:40];
          dec_ctrl        = 8'h1F;
          cls             = o_known(i_rx_data[39:36]) ? CLS_C : CLS_E;
        end
        BT_O0_C4: begin
          dec_data[7:0]  = o_to8(i_rx_data[35:32]);
          dec_data[31:8] = i_rx_data[31:8];
          for (int i = 0; i < 4; i++) dec_data[32+8*i +: 8] = ctl_7to8(i_rx_data[36+7*i +: 7]);
          dec_ctrl       = 8'hF1;
          cls            = o_known(i_rx_data[35:32]) ? CLS_C : CLS_E;
        end
        BT_O4_O0: begin
          dec_data[7:0]   = o_to8(i_rx_data[35:32]);
          dec_data[31:8]  = i_rx_data[31:8];
          dec_data[39:32] = o_to8(i_rx_data[39:36]);
          dec_data[63:40] = i_rx_data[63:40];
          dec_ctrl        = 8'h11;
          cls = (o_known(i_rx_data[35:32]) && o_known(i_rx_data[39:36])) ? CLS_C : CLS_E;
        end
        BT_S0: begin
          dec_data = {i_rx_data[63:8], 8'hFB};
          dec_ctrl = 8'h01;
          cls      = CLS_S;
        end
        BT_C4_S4: begin
          for (int i = 0; i < 4; i++) dec_data[8*i +: 8] = ctl_7to8(i_rx_data[8+7*i +: 7]);
          dec_data[39:32] = 8'hFB;
          dec_data[63:40] = i_rx_data[63:40];
          dec_ctrl        = 8'h1F;
          cls             = CLS_S;
        end
        BT_O0_S4: begin
          dec_data[7:0]   = o_to8(i_rx_data[35:32]);
          dec_data[31:8]  = i_rx_data[31:8];
          dec_data[39:32] = 8'hFB;
          dec_data[63:40] = i_rx_data[63:40];
          dec_ctrl        = 8'h11;
          cls             = o_known(i_rx_data[35:32]) ? CLS_S : CLS_E;
        end
        BT_T0: begin is_term = 1'b1; term_lane = 3'd0; end
        BT_T1: begin is_term = 1'b1; term_lane = 3'd1; end
        BT_T2: begin is_term = 1'b1; term_lane = 3'd2; end
        BT_T3: begin is_term = 1'b1; term_lane = 3'd3; end
        BT_T4: begin is_term = 1'b1; term_lane = 3'd4; end
        BT_T5: begin is_term = 1'b1; term_lane = 3'd5; end
        BT_T6: begin is_term = 1'b1; term_lane = 3'd6; end
        BT_T7: begin is_term = 1'b1; term_lane = 3'd7; end
        default: cls = CLS_E;
      endcase
      // Trailing control code for lane j always sits at bit 8+7j, whatever the terminate lane.
      if (is_term) begin
        for (int j = 0; j < 8; j++) begin
          if (j < int'(term_lane))       dec_data[8*j +: 8] = tail_data[8*j +: 8];
          else if (j == int'(term_lane)) dec_data[8*j +: 8] = 8'hFD;
          else                           dec_data[8*j +: 8] = ctl_7to8(i_rx_data[8+7*j +: 7]);
        end
        dec_ctrl = 8'hFF << term_lane;
        cls      = CLS_T;
      end
    end
  end

  always_comb begin
    state_nxt = RX_E;
    case (state)
      RX_INIT, RX_C: begin
        if (cls == CLS_C)      state_nxt = RX_C;
        else if (cls == CLS_S) state_nxt = RX_D;
      end
      RX_D: begin
        if (cls == CLS_D)      state_nxt = RX_D;
        else if (cls == CLS_T) state_nxt = RX_C;
      end
      RX_E: begin
        if (cls == CLS_C || cls == CLS_T) state_nxt = RX_C;
        else if (cls == CLS_D)            state_nxt = RX_D;
      end
      default: state_nxt = RX_E;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= RX_INIT;
      o_xgmii_data  <= LF_DATA;
      o_xgmii_ctrl  <= LF_CTRL;
      o_xgmii_valid <= 1'b0;
      o_decode_err  <= 1'b0;
      o_err_count   <= '0;
    end else begin
      o_xgmii_valid <= i_rx_valid;
      o_decode_err  <= 1'b0;
      if (i_rx_valid) begin
        if (!i_block_lock) begin
          state        <= RX_INIT;
          o_xgmii_data <= LF_DATA;
          o_xgmii_ctrl <= LF_CTRL;
        end else begin
          state <= state_nxt;
          if (state_nxt == RX_E) begin
            o_xgmii_data <= ERR_DATA;
            o_xgmii_ctrl <= '1;
            o_decode_err <= 1'b1;
            if (o_err_count != '1) o_err_count <= o_err_count + 1'b1;
          end else begin
            o_xgmii_data <= dec_data;
            o_xgmii_ctrl <= dec_ctrl;
          end
        end
      end
    end
  end

endmodule

// File: doc/xgmii_decoder_64b66b.md
Name: xgmii_decoder_64b66b

Overview:
Receive-path 64b/66b decoder per IEEE 802.3 Clause 49.2.11. It takes descrambled 66-bit blocks (2-bit sync header plus 64-bit payload) from the block-sync/descrambler stage. It runs the Clause 49 receive state machine and outputs one registered 64-bit XGMII data word with an 8-bit control word per valid block. It is the inverse of the team's 64b/66b XGMII encoder and shares its code and block-type constants.

Parameters:
DATA_WIDTH, 64, XGMII data width (fixed; other values are unsupported)
CTRL_WIDTH, 8, XGMII control width (DATA_WIDTH/8)
HDR_WIDTH, 2, sync header width
ERR_CNT_WIDTH, 8, width of the saturating error-block counter

Ports:
i_clk  in  1  clock for all logic
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  64  descrambled block payload; block type field at [7:0]
i_rx_hdr  in  2  sync header: 2'b01 = data, 2'b10 = control
i_rx_valid  in  1  qualifies i_rx_data/i_rx_hdr; one block per asserted cycle
i_block_lock  in  1  block-lock status from the sync stage
o_xgmii_data  out  64  decoded XGMII data; lane n = [8n+7:8n]
o_xgmii_ctrl  out  8  decoded XGMII control; bit n = lane n is a control character
o_xgmii_valid  out  1  output word valid
o_decode_err  out  1  one-cycle pulse with o_xgmii_valid when the emitted word is an error block
o_err_count  out  ERR_CNT_WIDTH  saturating count of emitted error blocks

Behaviour:
- Clock and reset: one clock (i_clk); reset is synchronous and active-high (i_reset).
- Reset values:
  - state = RX_INIT
  - o_xgmii_data = 64'h0100009C_0100009C (Local Fault)
  - o_xgmii_ctrl = 8'h11
  - o_xgmii_valid = 0, o_decode_err = 0, o_err_count = 0
- Latency: exactly 1 cycle from i_rx_valid to o_xgmii_valid. Outputs are registered.
- i_rx_valid = 0: state held, o_xgmii_data/o_xgmii_ctrl held, o_xgmii_valid = 0, o_decode_err = 0.
- i_block_lock = 0 while i_rx_valid = 1:
  - next state = RX_INIT; output is Local Fault (as at reset) with valid = 1.
  - No error flag and no count increment. Lock overrides everything else.
- 7-bit to 8-bit control mapping:
  - 00->07, 06->06, 1E->FE, 2D->1C, 33->3C, 4B->7C, 55->BC, 66->DC, 78->F7
  - Any other code -> FE.
  - O code: 0 -> 9C, F -> 5C, other -> block classed E.
- Block classes, decoded lane layouts and ctrl words:
  - D: header 01. Data = payload, ctrl = 00.
  - C, type 1E: eight codes at [63:8], ctrl = FF. Classed E if any code is unmapped.
  - C, type 2D: lanes 0-3 codes [35:8], lane 4 O [39:36], lanes 5-7 [63:40]; ctrl = 1F.
  - C, type 4B: lane 0 O [35:32], lanes 1-3 [31:8], lanes 4-7 codes [63:36]; ctrl = F1.
  - C, type 55: lane 0 O [35:32], lane 4 O [39:36], lanes 1-3 [31:8], lanes 5-7 [63:40]; ctrl = 11.
  - S, type 78: lane 0 = FB, lanes 1-7 [63:8]; ctrl = 01.
  - S, type 33: lanes 0-3 codes [35:8], lane 4 = FB, lanes 5-7 [63:40]; ctrl = 1F.
  - S, type 66: lane 0 O [35:32], lanes 1-3 [31:8], lane 4 = FB, lanes 5-7 [63:40]; ctrl = 11.
  - T_k (types 87, 99, AA, B4, CC, D2, E1, FF for k = 0..7):
    - lanes 0..k-1 data from [8k+7:8]; lane k = FD
    - lane j > k control code at bit 8+8k+(7-k)+7(j-k-1), 7 bits
    - ctrl = 8'hFF << k
  - E: header 00 or 11, or unknown block type.
- Error block: o_xgmii_data = {8{8'hFE}}, o_xgmii_ctrl = FF, o_decode_err = 1.
- State machine (evaluated only on valid, locked cycles):
  - RX_INIT: C -> RX_C; S -> RX_D; D/T/E -> RX_E.
  - RX_C: C -> RX_C; S -> RX_D; D/T/E -> RX_E.
  - RX_D: D -> RX_D; T -> RX_C; C/S/E -> RX_E.
  - RX_E: C -> RX_C; D -> RX_D; T -> RX_C; S/E -> RX_E.
  - A block whose transition lands in RX_E is emitted as an error block. Otherwise it is emitted decoded.
- o_err_count increments on every emitted error block and saturates at 2^ERR_CNT_WIDTH-1. It is cleared only by reset.
- Reset asserted mid-frame: reset values on the next edge. After reset, a D block is an error until an S or C block arrives.

Test Plan:
- Idle: hdr 10, payload 0x0000000000000000_1E after a C block -> data 0x0707070707070707, ctrl FF, valid one cycle later, no error.
- Frame: S0 payload {0x20100E0D0C0B0A, 78}, then D 0x0807060504030201, then T7 {0xFD2211EEDDCCBBAA minus FD byte, FF} -> data 0x20100E0D0C0B0AFB ctrl 01; data 0x0807060504030201 ctrl 00; data 0xFD2211EEDDCCBBAA ctrl 80. Round-trip against the encoder golden model for T0..T7 and S4.
- Sequencing error: after reset-then-C, send a D block -> all FE, ctrl FF, o_decode_err = 1, o_err_count = 1. Next C block decodes normally.
- Invalid header: hdr 2'b11 in RX_D -> error block. 300 consecutive errors -> o_err_count saturates at 255.
- Lock loss: i_block_lock = 0 mid-frame -> LF 0x0100009C0100009C, ctrl 11, no count increment. Relock plus D block -> error block. Relock plus S block -> normal decode.
- Valid gaps: toggle i_rx_valid 1/0 mid-frame -> outputs and state held, o_xgmii_valid deasserts, decoded sequence identical to the gap-free run.
